tof_i2c_cmd_sequencer: RTL

TOF_I2C_CMD_SEQUENCER -- requirements
Module: tof_i2c_cmd_sequencer

---
 rtl/tof_i2c_cmd_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/tof_i2c_cmd_sequencer.sv
// Queues single-byte register writes for a ToF sensor and plays them out to an
// I2C master, retrying failed or timed-out attempts and aborting stickily.
module tof_i2c_cmd_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_RETRY  = 3,
  parameter int TIMEOUT    = 20000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [15:0]                 cmd_reg_addr,
  input  logic [7:0]                  cmd_data,
  input  logic [6:0]                  dev_addr,
  input  logic                        i2c_ready,
  input  logic                        i2c_error,
  output logic [6:0]                  i2c_slave_adress,
  output logic [15:0]                 i2c_register_address,
  output logic [7:0]                  i2c_data,
  output logic                        i2c_is_read,
  output logic [9:0]                  i2c_nb_of_bytes,
  output logic                        i2c_start,
  output logic                        busy,
  output logic                        done,
  output logic                        error_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_DONE, CHECK, ABORT} state_t;
  state_t state, state_next;

  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, flush;
  logic          ready_q, rise, fail, tmo_hit;
  logic [TW-1:0] tcnt;
  logic [RW-1:0] retry;

  // Only a low->high transition of i2c_ready counts as completion.
  assign rise        = i2c_ready && !ready_q;
  assign tmo_hit     = (tcnt == TW'(TIMEOUT - 1));
  assign cmd_ready   = reset && (count != (AW+1)'(FIFO_DEPTH)) && !error_out;
  assign push        = cmd_valid && cmd_ready;
  assign pop         = (state == IDLE) && (count != '0);
  assign flush       = (state_next == ABORT);
  assign fifo_count  = count;
  assign i2c_is_read = 1'b0;
  assign i2c_nb_of_bytes = 10'd1;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {cmd_reg_addr, cmd_data};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      ready_q              <= 1'b0;
      tcnt                 <= '0;
      retry                <= '0;
      fail                 <= 1'b0;
      i2c_slave_adress     <= '0;
      i2c_register_address <= '0;
      i2c_data             <= '0;
    end else begin
      state   <= state_next;
      ready_q <= i2c_ready;
      // Launch registers are only loaded on pop, so retries replay the same command.
      if (pop) begin
        {i2c_register_address, i2c_data} <= mem[rd_ptr];
        i2c_slave_adress                 <= dev_addr;
      end
      case (state)
        LAUNCH: tcnt <= '0;
        WAIT_DONE: begin
          if (rise)         fail <= i2c_error;
          else if (tmo_hit) fail <= 1'b1;
          else              tcnt <= tcnt + 1'b1;
        end
        CHECK: begin
          if (!fail)                          retry <= '0;
          else if (retry < RW'(MAX_RETRY))    retry <= retry + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    i2c_start  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error_out  = 1'b0;
    case (state)
      IDLE: if (count != '0) state_next = LAUNCH;
      LAUNCH: begin
        i2c_start  = 1'b1;
        busy       = 1'b1;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (rise || tmo_hit) state_next = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (!fail) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (retry < RW'(MAX_RETRY)) begin
          state_next = LAUNCH;
        end else begin
          state_next = ABORT;
        end
      end
      ABORT:   error_out = 1'b1;
      default: state_next = IDLE;
    endcase
  end
endmodule
